// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Holds the divider FSM encoding plus the default counter width and half-period.
package clk_div_pkg;

   localparam int CLK_DIV_CNT_W    = 8;
   localparam int CLK_DIV_DEF_HALF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

endpackage

// File: rtl/clk_fixed_div.sv
// Free-running registered clk/2 and clk/4 outputs.
// Both run from reset release regardless of the programmable divider enable.
module clk_fixed_div (
   input  logic clk,
   input  logic rst,
   output logic clk_half,
   output logic clk_quarter
);

   logic half_reg;
   logic quarter_reg;

   // clk/4 advances only when clk/2 is high, giving a clean 4-cycle period
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_reg    <= 1'b0;
         quarter_reg <= 1'b0;
      end else begin
         half_reg <= ~half_reg;
         if (half_reg)
            quarter_reg <= ~quarter_reg;
      end
   end

   assign clk_half    = half_reg;
   assign clk_quarter = quarter_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Programmable divided clock with edge strobes and glitch-free reload
// at full-period boundaries, plus fixed clk/2 and clk/4 outputs.
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = CLK_DIV_CNT_W,
   parameter int DEF_HALF = CLK_DIV_DEF_HALF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] half_in,
   input  logic             load,
   output logic             clk_div,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic             clk_half,
   output logic             clk_quarter,
   output logic             busy
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] half_reg, half_next;
   logic [CNT_W-1:0] pend_reg, pend_next;
   logic             div_reg, div_next;
   logic             rise_reg, rise_next;
   logic             fall_reg, fall_next;
   logic [CNT_W-1:0] half_clamped;
   logic             toggle;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         half_reg  <= HALF_RST;
         pend_reg  <= HALF_RST;
         div_reg   <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         half_reg  <= half_next;
         pend_reg  <= pend_next;
         div_reg   <= div_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      half_next    = half_reg;
      pend_next    = pend_reg;
      div_next     = div_reg;
      rise_next    = 1'b0;
      fall_next    = 1'b0;
      half_clamped = (half_in == '0) ? CNT_ONE : half_in;
      toggle       = (cnt_reg >= half_reg - CNT_ONE);

      case (state_reg)
         ST_IDLE: begin
            if (load)
               half_next = half_clamped;
            if (en) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end

         ST_RUN, ST_PEND: begin
            if (!en) begin
               // Leaving the run: a fresh load wins over an older pending value
               state_next = ST_IDLE;
               if (load)
                  half_next = half_clamped;
               else if (state_reg == ST_PEND)
                  half_next = pend_reg;
            end else begin
               if (toggle) begin
                  cnt_next  = '0;
                  div_next  = ~div_reg;
                  rise_next = ~div_reg;
                  fall_next = div_reg;
                  // New half-period only lands on a falling edge so no pulse is cut short
                  if (div_reg && (state_reg == ST_PEND)) begin
                     half_next  = pend_reg;
                     state_next = ST_RUN;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
               if (load) begin
                  pend_next  = half_clamped;
                  state_next = ST_PEND;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   assign clk_div   = div_reg;
   assign rise_tick = rise_reg;
   assign fall_tick = fall_reg;
   assign busy      = (state_reg == ST_PEND);

   clk_fixed_div u_fixed (
      .clk         (clk),
      .rst         (rst),
      .clk_half    (clk_half),
      .clk_quarter (clk_quarter)
   );

endmodule
